// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync RAM between instruction fetch (IF) and data (D) ports.
// Latency: grant combinational with request; read data returned exactly 1 cycle after grant.
// Backpressure: the losing port simply sees no gnt and must hold its request; D wins unless IF is starved.
module mem_port_arbiter #(
    parameter int WIDTH        = 32,
    parameter int ADDRSIZE     = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDRSIZE-1:0] if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [WIDTH-1:0]    if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDRSIZE-1:0] d_addr,
    input  logic [WIDTH-1:0]    d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [WIDTH-1:0]    d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    owner_t             r_rd_owner;
    owner_t             w_rd_owner_nxt;
    logic [3:0]         r_starve_cnt;
    logic [3:0]         w_starve_nxt;
    logic [WIDTH-1:0]   r_if_hold;
    logic [WIDTH-1:0]   r_d_hold;
    logic               w_if_pri;
    logic               w_if_gnt;
    logic               w_d_gnt;

    // IF wins when it is alone or when D has used up its run of consecutive grants.
    // Grants are gated by reset so nothing reaches the RAM while reset is held.
    assign w_if_pri = if_req & (~d_req | (r_starve_cnt == LP_LIMIT));
    assign w_if_gnt = rst & w_if_pri;
    assign w_d_gnt  = rst & d_req & ~w_if_pri;

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign if_rvalid = (r_rd_owner == OWN_IF);
    assign d_rvalid  = (r_rd_owner == OWN_D);

    // Data passes straight through in the return cycle; otherwise the last return is replayed.
    assign if_rdata = if_rvalid ? mem_rdata : r_if_hold;
    assign d_rdata  = d_rvalid  ? mem_rdata : r_d_hold;

    // RAM request mux: granted port drives address/data, bus is all-zero when idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (w_d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // Starvation counter: counts D wins while IF waits, saturates, clears once IF is served or idle.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!if_req || w_if_gnt) begin
            w_starve_nxt = 4'd0;
        end else if (w_d_gnt && (r_starve_cnt < LP_LIMIT)) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
        end
    end

    // Next read-return owner: whichever port issued a read this cycle (writes return nothing).
    always_comb begin
        w_rd_owner_nxt = OWN_NONE;
        if (w_if_gnt) begin
            w_rd_owner_nxt = OWN_IF;
        end else if (w_d_gnt && !d_we) begin
            w_rd_owner_nxt = OWN_D;
        end
    end

    // State registers; an in-flight read is dropped by reset and never returns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_owner   <= OWN_NONE;
            r_starve_cnt <= 4'd0;
        end else begin
            r_rd_owner   <= w_rd_owner_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Capture returned read data so each port keeps its last result after rvalid drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_hold <= '0;
            r_d_hold  <= '0;
        end else begin
            if (r_rd_owner == OWN_IF) r_if_hold <= mem_rdata;
            if (r_rd_owner == OWN_D)  r_d_hold  <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of per-cycle vectors plus reset/idle sequences.
// A behavioural sync RAM sits on the mem_* bus; read results go through per-port expectation queues.
// Outputs are sampled on the falling edge, inputs driven 1 time unit after the rising edge.
module tb_mem_port_arbiter;

    localparam int W  = 32;
    localparam int AW = 12;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [W-1:0]  if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [W-1:0]  d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [W-1:0]  d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] if_q[$];
    logic [W-1:0] d_q[$];

    mem_port_arbiter #(.WIDTH(W), .ADDRSIZE(AW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] init_word(input logic [AW-1:0] a);
        if (a == 12'd5) return 32'hDEAD_BEEF;
        return {20'hC0DE0, a};
    endfunction

    // Behavioural single-port synchronous RAM.
    logic [W-1:0] ram [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = init_word(AW'(i));
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Read-data scoreboard: every rvalid must match the oldest outstanding expected read.
    always @(negedge clk) begin
        if (if_rvalid === 1'b1) begin
            if (if_q.size() == 0) chk("if_rvalid_unexpected", 32'(if_rvalid), 32'd0);
            else                  chk("if_rdata", if_rdata, if_q.pop_front());
        end
        if (d_rvalid === 1'b1) begin
            if (d_q.size() == 0) chk("d_rvalid_unexpected", 32'(d_rvalid), 32'd0);
            else                 chk("d_rdata", d_rdata, d_q.pop_front());
        end
    end

    typedef struct {
        logic          ir;
        logic [AW-1:0] ia;
        logic          dr;
        logic          dwe;
        logic [AW-1:0] da;
        logic [W-1:0]  dwd;
        logic          eig;
        logic          edg;
        logic          een;
        logic          ewe;
        logic [AW-1:0] eaddr;
        logic [W-1:0]  ewd;
        logic          eirv;
        logic          edrv;
        int            est;
        logic [W-1:0]  erd;
        logic          chk_hold;
        logic [W-1:0]  eih;
        logic [W-1:0]  edh;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v_zero();
        vec_t v;
        v = '{ir:0, ia:0, dr:0, dwe:0, da:0, dwd:0, eig:0, edg:0, een:0, ewe:0,
              eaddr:0, ewd:0, eirv:0, edrv:0, est:0, erd:0, chk_hold:0, eih:0, edh:0};
        return v;
    endfunction

    task automatic add_idle(input int est, input logic eirv, input logic edrv,
                            input logic ch, input logic [W-1:0] eih, input logic [W-1:0] edh);
        vec_t v = v_zero();
        v.est = est; v.eirv = eirv; v.edrv = edrv; v.chk_hold = ch; v.eih = eih; v.edh = edh;
        vecs.push_back(v);
    endtask

    task automatic add_if(input logic [AW-1:0] a, input logic [W-1:0] erd, input logic eirv);
        vec_t v = v_zero();
        v.ir = 1; v.ia = a; v.eig = 1; v.een = 1; v.eaddr = a; v.erd = erd; v.eirv = eirv;
        vecs.push_back(v);
    endtask

    task automatic add_d(input logic we, input logic [AW-1:0] a, input logic [W-1:0] wd,
                         input logic [W-1:0] erd, input int est, input logic edrv);
        vec_t v = v_zero();
        v.dr = 1; v.dwe = we; v.da = a; v.dwd = wd;
        v.edg = 1; v.een = 1; v.ewe = we; v.eaddr = a; v.ewd = wd;
        v.erd = erd; v.est = est; v.edrv = edrv;
        vecs.push_back(v);
    endtask

    task automatic add_both(input logic gi, input int est, input logic eirv, input logic edrv);
        vec_t v = v_zero();
        v.ir = 1; v.ia = 12'd7; v.dr = 1; v.dwe = 0; v.da = 12'd9; v.dwd = 32'hFFFF_0000;
        v.eig = gi; v.edg = !gi; v.een = 1;
        v.eaddr = gi ? 12'd7 : 12'd9;
        v.ewd   = gi ? 32'd0 : 32'hFFFF_0000;
        v.erd   = gi ? init_word(12'd7) : init_word(12'd9);
        v.est = est; v.eirv = eirv; v.edrv = edrv;
        vecs.push_back(v);
    endtask

    task automatic build_table();
        // single fetch and hold
        add_idle(0, 0, 0, 1, 32'd0, 32'd0);
        add_if(12'd5, 32'hDEAD_BEEF, 0);
        add_idle(0, 1, 0, 0, 0, 0);
        add_idle(0, 0, 0, 1, 32'hDEAD_BEEF, 32'd0);
        // write then read same address
        add_d(1, 12'd3, 32'h1234_5678, 32'd0, 0, 0);
        add_d(0, 12'd3, 32'd0, 32'h1234_5678, 0, 0);
        add_idle(0, 0, 1, 0, 0, 0);
        add_idle(0, 0, 0, 1, 32'hDEAD_BEEF, 32'h1234_5678);
        // back-to-back fetch 0..3 (word 3 was just overwritten)
        for (int i = 0; i < 4; i++)
            add_if(AW'(i), (i == 3) ? 32'h1234_5678 : init_word(AW'(i)), i > 0);
        add_idle(0, 1, 0, 0, 0, 0);
        add_idle(0, 0, 0, 1, 32'h1234_5678, 32'h1234_5678);
        // contention: D,D,D,D,I repeated
        for (int k = 0; k < 10; k++)
            add_both((k % 5) == 4, k % 5, k == 5, (k >= 1) && (k != 5));
        add_idle(0, 1, 0, 0, 0, 0);
        add_idle(0, 0, 0, 1, init_word(12'd7), init_word(12'd9));
        // counter clears when IF withdraws
        add_both(0, 0, 0, 0);
        add_both(0, 1, 0, 1);
        add_d(0, 12'd9, 32'd0, init_word(12'd9), 2, 1);
        add_idle(0, 0, 1, 0, 0, 0);
        add_idle(0, 0, 0, 1, init_word(12'd7), init_word(12'd9));
    endtask

    task automatic drive_idle();
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " if_gnt"},    32'(if_gnt), 32'd0);
        chk({tag, " d_gnt"},     32'(d_gnt), 32'd0);
        chk({tag, " if_rvalid"}, 32'(if_rvalid), 32'd0);
        chk({tag, " d_rvalid"},  32'(d_rvalid), 32'd0);
        chk({tag, " mem_en"},    32'(mem_en), 32'd0);
        chk({tag, " mem_we"},    32'(mem_we), 32'd0);
        chk({tag, " mem_addr"},  32'(mem_addr), 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, " starve"},    32'(dut.r_starve_cnt), 32'd0);
    endtask

    initial begin
        vec_t v;
        string p;
        rst = 1'b0;
        drive_idle();
        if_req = 1'b1;
        #2;
        chk_quiet("in_reset");
        chk("in_reset if_rdata", if_rdata, 32'd0);
        chk("in_reset d_rdata", d_rdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        if_req = 1'b0;

        build_table();
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(posedge clk);
            #1;
            if_req = v.ir; if_addr = v.ia;
            d_req = v.dr; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd;
            @(negedge clk);
            p = $sformatf("row%0d", i);
            chk({p, " if_gnt"},    32'(if_gnt), 32'(v.eig));
            chk({p, " d_gnt"},     32'(d_gnt), 32'(v.edg));
            chk({p, " mem_en"},    32'(mem_en), 32'(v.een));
            chk({p, " mem_we"},    32'(mem_we), 32'(v.ewe));
            chk({p, " mem_addr"},  32'(mem_addr), 32'(v.eaddr));
            chk({p, " mem_wdata"}, mem_wdata, v.ewd);
            chk({p, " if_rvalid"}, 32'(if_rvalid), 32'(v.eirv));
            chk({p, " d_rvalid"},  32'(d_rvalid), 32'(v.edrv));
            chk({p, " starve"},    32'(dut.r_starve_cnt), 32'(v.est));
            if (v.chk_hold) begin
                chk({p, " if_hold"}, if_rdata, v.eih);
                chk({p, " d_hold"},  d_rdata, v.edh);
            end
            if (v.eig)            if_q.push_back(v.erd);
            if (v.edg && !v.dwe)  d_q.push_back(v.erd);
        end

        // Reset lands between a D read grant and its return edge.
        @(posedge clk);
        #1;
        drive_idle();
        d_req = 1; d_we = 0; d_addr = 12'd5;
        @(negedge clk);
        chk("rst_mid d_gnt_before", 32'(d_gnt), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk_quiet("rst_mid low");
        chk("rst_mid d_rdata", d_rdata, 32'd0);
        chk("rst_mid if_rdata", if_rdata, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid d_rvalid_after_edge", 32'(d_rvalid), 32'd0);
        chk("rst_mid mem_en_held_req", 32'(mem_en), 32'd0);
        d_req = 0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_quiet($sformatf("post_rst%0d", i));
            chk("post_rst d_rdata", d_rdata, 32'd0);
        end

        // Port is usable again after reset.
        @(posedge clk);
        #1;
        if_req = 1; if_addr = 12'd2;
        @(negedge clk);
        chk("post_rst if_gnt", 32'(if_gnt), 32'd1);
        if_q.push_back(init_word(12'd2));
        @(posedge clk);
        #1;
        if_req = 0;
        @(negedge clk);
        chk("post_rst if_rvalid", 32'(if_rvalid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("post_rst if_hold", if_rdata, init_word(12'd2));

        chk("if_q drained", 32'(if_q.size()), 32'd0);
        chk("d_q drained", 32'(d_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
